// File: rtl/sync_edge_filter.sv
// Glitch filter for a synchronised single-bit level: a new value must persist for
// STABLE_CYCLES samples before level_out follows, with edge pulses and a rise counter.
module sync_edge_filter #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_in,
  input  logic                 cnt_clr,
  output logic                 level_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] edge_count,
  output logic                 overflow
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  // Counter value on the sample that completes a qualification; zero means a
  // single differing sample is enough, so the CHECK states are skipped.
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW        = 2'd0,
    CHECK_HIGH = 2'd1,
    HIGH       = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        stab_q, stab_d;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic [CW-1:0]        stab_inc;
  logic                 stab_done;

  assign stab_inc  = stab_q + CW'(1);
  assign stab_done = (stab_q == STABLE_LAST);

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      LOW: begin
        if (sync_in) begin
          if (stab_done) begin
            state_d = HIGH;
            stab_d  = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = CHECK_HIGH;
            stab_d  = stab_inc;
          end
        end
      end
      CHECK_HIGH: begin
        if (!sync_in) begin
          state_d = LOW;
          stab_d  = '0;
        end else if (stab_done) begin
          state_d = HIGH;
          stab_d  = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          stab_d = stab_inc;
        end
      end
      HIGH: begin
        if (!sync_in) begin
          if (stab_done) begin
            state_d = LOW;
            stab_d  = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = CHECK_LOW;
            stab_d  = stab_inc;
          end
        end
      end
      CHECK_LOW: begin
        if (sync_in) begin
          state_d = HIGH;
          stab_d  = '0;
        end else if (stab_done) begin
          state_d = LOW;
          stab_d  = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          stab_d = stab_inc;
        end
      end
      default: begin
        state_d = LOW;
        stab_d  = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // Clear takes effect before a coincident rise is counted.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (cnt_clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end
    if (rise_d) begin
      if (cnt_clr) begin
        cnt_d = CNT_WIDTH'(1);
      end else if (&cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      stab_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign edge_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Directed bench for sync_edge_filter: default build, a 2-bit counter build for
// saturation, and a STABLE_CYCLES=1 build acting as a one-cycle delay.
module tb_sync_edge_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       sync_in_a = 1'b1, cnt_clr_a = 1'b0;
  logic       level_a, rise_a, fall_a, ovf_a;
  logic [7:0] count_a;

  logic       sync_in_b = 1'b0, cnt_clr_b = 1'b0;
  logic       level_b, rise_b, fall_b, ovf_b;
  logic [1:0] count_b;

  logic       sync_in_c = 1'b0, cnt_clr_c = 1'b0;
  logic       level_c, rise_c, fall_c, ovf_c;
  logic [7:0] count_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_edge_filter #(.STABLE_CYCLES(4), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .sync_in(sync_in_a), .cnt_clr(cnt_clr_a),
    .level_out(level_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
    .edge_count(count_a), .overflow(ovf_a)
  );

  sync_edge_filter #(.STABLE_CYCLES(4), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .sync_in(sync_in_b), .cnt_clr(cnt_clr_b),
    .level_out(level_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
    .edge_count(count_b), .overflow(ovf_b)
  );

  sync_edge_filter #(.STABLE_CYCLES(1), .CNT_WIDTH(8)) dut_c (
    .clk(clk), .rst(rst), .sync_in(sync_in_c), .cnt_clr(cnt_clr_c),
    .level_out(level_c), .rise_pulse(rise_c), .fall_pulse(fall_c),
    .edge_count(count_c), .overflow(ovf_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles on dut_a and reports whether any pulse was seen.
  task automatic watch_a(input int n, output logic saw_rise, output logic saw_fall);
    saw_rise = 1'b0;
    saw_fall = 1'b0;
    repeat (n) begin
      step();
      saw_rise = saw_rise | rise_a;
      saw_fall = saw_fall | fall_a;
    end
  endtask

  logic       sr, sf;
  logic [7:0] vec_c;
  logic       prev_c;
  int         exp_rises_c;
  logic [1:0] exp_cnt_b;
  logic       exp_ovf_b;

  initial begin
    // Reset held two cycles with sync_in_a high
    step();
    step();
    check("rst_level", level_a, 0);
    check("rst_rise", rise_a, 0);
    check("rst_fall", fall_a, 0);
    check("rst_count", count_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_count_b", count_b, 0);
    check("rst_level_c", level_c, 0);

    rst = 1'b0;
    watch_a(3, sr, sf);
    check("post_rst_no_early_rise", sr, 0);
    check("post_rst_level_low", level_a, 0);
    step();
    check("post_rst_rise", rise_a, 1);
    check("post_rst_level", level_a, 1);
    check("post_rst_count", count_a, 1);
    step();
    check("rise_one_cycle", rise_a, 0);
    check("level_held", level_a, 1);

    // Clean fall
    sync_in_a = 1'b0;
    watch_a(3, sr, sf);
    check("fall_not_early", sf, 0);
    check("fall_level_still_high", level_a, 1);
    step();
    check("fall_pulse", fall_a, 1);
    check("fall_level", level_a, 0);
    check("fall_no_count", count_a, 1);
    step();
    check("fall_one_cycle", fall_a, 0);

    // Three-sample high glitch while low
    sync_in_a = 1'b1;
    watch_a(3, sr, sf);
    sync_in_a = 1'b0;
    watch_a(6, sr, sf);
    check("glitch_hi_no_rise", sr, 0);
    check("glitch_hi_level", level_a, 0);
    check("glitch_hi_count", count_a, 1);

    // Second clean rise
    sync_in_a = 1'b1;
    watch_a(3, sr, sf);
    check("rise2_level_low", level_a, 0);
    step();
    check("rise2_pulse", rise_a, 1);
    check("rise2_count", count_a, 2);

    // Three-sample low glitch while high
    sync_in_a = 1'b0;
    watch_a(3, sr, sf);
    sync_in_a = 1'b1;
    watch_a(6, sr, sf);
    check("glitch_lo_no_fall", sf, 0);
    check("glitch_lo_level", level_a, 1);

    // Clear coincident with a rise at edge_count=2
    sync_in_a = 1'b0;
    watch_a(4, sr, sf);
    check("fall2_seen", sf, 1);
    check("fall2_count", count_a, 2);
    sync_in_a = 1'b1;
    watch_a(3, sr, sf);
    check("coinc_no_early_rise", sr, 0);
    cnt_clr_a = 1'b1;
    step();
    cnt_clr_a = 1'b0;
    check("coinc_rise", rise_a, 1);
    check("coinc_count", count_a, 1);
    check("coinc_ovf", ovf_a, 0);

    // Reset in the middle of a rise qualification
    sync_in_a = 1'b0;
    watch_a(4, sr, sf);
    check("fall3_seen", sf, 1);
    sync_in_a = 1'b1;
    watch_a(2, sr, sf);
    check("midrst_no_rise_before", sr, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_rise", rise_a, 0);
    check("midrst_level", level_a, 0);
    check("midrst_count", count_a, 0);
    watch_a(3, sr, sf);
    check("midrst_no_early_rise", sr, 0);
    step();
    check("midrst_rise_at_4", rise_a, 1);
    check("midrst_count_after", count_a, 1);

    // Saturation on the 2-bit counter build
    for (int i = 0; i < 4; i++) begin
      exp_cnt_b = (i < 3) ? 2'(i + 1) : 2'd3;
      exp_ovf_b = (i == 3);
      sync_in_b = 1'b1;
      repeat (4) step();
      check("sat_rise", rise_b, 1);
      check("sat_count", count_b, exp_cnt_b);
      check("sat_ovf", ovf_b, exp_ovf_b);
      sync_in_b = 1'b0;
      repeat (5) step();
    end
    check("sat_ovf_sticky", ovf_b, 1);
    check("sat_count_held", count_b, 3);
    cnt_clr_b = 1'b1;
    step();
    cnt_clr_b = 1'b0;
    check("clr_count", count_b, 0);
    check("clr_ovf", ovf_b, 0);
    check("clr_level_untouched", level_b, 0);

    // STABLE_CYCLES=1 behaves as a one-cycle delay
    vec_c       = 8'b1011_0010;
    prev_c      = 1'b0;
    exp_rises_c = 0;
    for (int i = 0; i < 8; i++) begin
      sync_in_c = vec_c[i];
      step();
      if (vec_c[i] && !prev_c) exp_rises_c++;
      check("s1_level", level_c, vec_c[i]);
      check("s1_rise", rise_c, vec_c[i] & ~prev_c);
      check("s1_fall", fall_c, ~vec_c[i] & prev_c);
      prev_c = vec_c[i];
    end
    check("s1_count", count_c, exp_rises_c);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
